// File: rtl/nds_async_fifo_wr_packer_pkg.sv
// rtl/nds_async_fifo_wr_packer_pkg.sv - shared FSM encoding and width helper for the FIFO write packer
package nds_async_fifo_wr_packer_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CLR = 1'b1
  } wr_state_t;

  function automatic int nds_clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/nds_async_fifo_wr_packer.sv
// rtl/nds_async_fifo_wr_packer.sv - packs narrow source beats into FIFO words and owns the write-side clear
module nds_async_fifo_wr_packer
  import nds_async_fifo_wr_packer_pkg::*;
#(
  parameter  int IN_WIDTH   = 8,
  parameter  int OUT_WIDTH  = 32,
  parameter  int CLR_CYCLES = 2,
  localparam int R          = OUT_WIDTH / IN_WIDTH,
  localparam int LW         = nds_clog2(R)
) (
  input  logic                 w_clk,
  input  logic                 w_reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  input  logic                 clr_req,
  output logic                 clr_done,
  output logic                 fifo_wr,
  output logic [OUT_WIDTH-1:0] fifo_wr_data,
  output logic                 fifo_clr,
  input  logic                 fifo_full,
  output logic [LW:0]          last_lanes,
  output logic [15:0]          word_cnt
);

  wr_state_t              r_state;
  wr_state_t              w_state_nxt;
  logic [LW-1:0]          r_lane_cnt;
  logic [OUT_WIDTH-1:0]   r_pack_q;
  logic [OUT_WIDTH-1:0]   r_out_q;
  logic                   r_out_vld_q;
  logic [3:0]             r_clr_cnt;
  logic                   r_clr_done;
  logic [LW:0]            r_last_lanes;
  logic [15:0]            r_word_cnt;

  logic                   w_fifo_wr;
  logic                   w_out_free;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_clr_last;
  logic [OUT_WIDTH-1:0]   w_packed;

  // Write strobe comes only from flops so the FIFO never sees a path from the source.
  assign w_fifo_wr  = r_out_vld_q & ~fifo_full;
  assign w_out_free = ~r_out_vld_q | w_fifo_wr;
  assign w_accept   = in_valid & w_in_ready;
  assign w_push     = w_accept & ((r_lane_cnt == LW'(R - 1)) | in_last);
  assign w_clr_last = (r_clr_cnt == 4'(CLR_CYCLES - 1));

  always_comb begin
    w_packed = r_pack_q;
    w_packed[r_lane_cnt*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) r_state <= ST_RUN;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    fifo_clr    = 1'b0;
    case (r_state)
      ST_RUN: begin
        // The cycle carrying clr_done still holds off the source.
        w_in_ready = w_out_free & ~r_clr_done;
        if (clr_req) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        fifo_clr = 1'b1;
        if (!clr_req && w_clr_last) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_lane_cnt   <= '0;
      r_pack_q     <= '0;
      r_out_q      <= '0;
      r_out_vld_q  <= 1'b0;
      r_clr_cnt    <= '0;
      r_clr_done   <= 1'b0;
      r_last_lanes <= '0;
      r_word_cnt   <= '0;
    end else begin
      r_clr_done <= 1'b0;
      if (r_state == ST_CLR) begin
        r_clr_cnt  <= clr_req ? 4'd0 : r_clr_cnt + 4'd1;
        r_clr_done <= ~clr_req & w_clr_last;
      end else if (clr_req) begin
        // Clear wins over any beat handshake or pending word in this cycle.
        r_clr_cnt   <= '0;
        r_pack_q    <= '0;
        r_lane_cnt  <= '0;
        r_out_vld_q <= 1'b0;
        r_word_cnt  <= '0;
      end else begin
        r_word_cnt <= r_word_cnt + {15'd0, w_fifo_wr};
        if (w_push) begin
          r_out_q     <= w_packed;
          r_out_vld_q <= 1'b1;
          r_pack_q    <= '0;
          r_lane_cnt  <= '0;
        end else begin
          if (w_fifo_wr) r_out_vld_q <= 1'b0;
          if (w_accept) begin
            r_pack_q   <= w_packed;
            r_lane_cnt <= r_lane_cnt + LW'(1);
          end
        end
        if (w_accept && in_last) r_last_lanes <= {1'b0, r_lane_cnt} + {{LW{1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign clr_done     = r_clr_done;
  assign fifo_wr      = w_fifo_wr;
  assign fifo_wr_data = r_out_q;
  assign last_lanes   = r_last_lanes;
  assign word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_nds_async_fifo_wr_packer.sv
// tb/tb_nds_async_fifo_wr_packer.sv - directed self-checking bench for the FIFO write packer
module tb_nds_async_fifo_wr_packer;

  logic        w_clk = 1'b0;
  logic        w_reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        clr_req = 1'b0;
  logic        clr_done;
  logic        fifo_wr;
  logic [31:0] fifo_wr_data;
  logic        fifo_clr;
  logic        fifo_full = 1'b0;
  logic [2:0]  last_lanes;
  logic [15:0] word_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stall = 0;
  bit t6 = 1'b0;
  logic [31:0] wq[$];
  int          wc[$];

  nds_async_fifo_wr_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .CLR_CYCLES(2)) dut (
    .w_clk(w_clk), .w_reset_n(w_reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clr_req(clr_req), .clr_done(clr_done),
    .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .fifo_clr(fifo_clr),
    .fifo_full(fifo_full), .last_lanes(last_lanes), .word_cnt(word_cnt)
  );

  always #5 w_clk = ~w_clk;

  // Writes are logged mid-cycle, where the values equal what the next rising edge will see.
  always @(negedge w_clk) begin
    cyc++;
    if (fifo_wr) begin
      wq.push_back(fifo_wr_data);
      wc.push_back(cyc);
    end
    if (t6 && in_valid && !in_ready) stall++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge w_clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge w_clk);
    end
    if (t >= 200) check_val("send_timeout", 32'd1, 32'd0);
    @(posedge w_clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge w_clk);
    @(posedge w_clk); #1;
  endtask

  initial begin
    int viol;
    repeat (3) @(posedge w_clk);
    #1 w_reset_n = 1'b1;
    @(negedge w_clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check_val("rst_fifo_clr", 32'(fifo_clr), 32'd0);
    check_val("rst_clr_done", 32'(clr_done), 32'd0);
    check_val("rst_last_lanes", 32'(last_lanes), 32'd0);
    check_val("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge w_clk); #1;

    // 1: two full words
    for (int i = 1; i <= 8; i++) send_beat(8'(i * 8'h11), 1'b0);
    idle(3);
    check_val("t1_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check_val("t1_w0", wq[0], 32'h44332211);
      check_val("t1_w1", wq[1], 32'h88776655);
    end
    check_val("t1_word_cnt", 32'(word_cnt), 32'd2);
    wq.delete();

    // 2: partial word on in_last, then realignment to lane 0
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b0);
    send_beat(8'hA3, 1'b1);
    idle(2);
    check_val("t2_last_lanes", 32'(last_lanes), 32'd3);
    for (int i = 1; i <= 4; i++) send_beat(8'hB0 + 8'(i), 1'b0);
    idle(2);
    check_val("t2_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check_val("t2_w0", wq[0], 32'h00A3A2A1);
      check_val("t2_w1", wq[1], 32'hB4B3B2B1);
    end
    check_val("t2_word_cnt", 32'(word_cnt), 32'd4);
    wq.delete();

    // 3: backpressure from fifo_full
    fifo_full = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(8'hC0 + 8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hC5;
    viol = 0;
    repeat (10) begin
      @(negedge w_clk);
      if (fifo_wr || in_ready) viol++;
      if (fifo_wr_data !== 32'hC4C3C2C1) viol++;
    end
    check_val("t3_stall_viol", 32'(viol), 32'd0);
    check_val("t3_no_wr", 32'(wq.size()), 32'd0);
    @(posedge w_clk); #1 fifo_full = 1'b0;
    @(negedge w_clk);
    check_val("t3_wr_after", 32'(fifo_wr), 32'd1);
    check_val("t3_data_after", fifo_wr_data, 32'hC4C3C2C1);
    check_val("t3_ready_after", 32'(in_ready), 32'd1);
    @(posedge w_clk); #1 in_valid = 1'b0;
    for (int i = 6; i <= 8; i++) send_beat(8'hC0 + 8'(i), 1'b0);
    idle(2);
    check_val("t3_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) check_val("t3_w1", wq[1], 32'hC8C7C6C5);
    check_val("t3_word_cnt", 32'(word_cnt), 32'd6);
    wq.delete();

    // 4: clear after two lanes packed
    send_beat(8'hD1, 1'b0);
    send_beat(8'hD2, 1'b0);
    clr_req = 1'b1;
    @(posedge w_clk); #1 clr_req = 1'b0;
    @(negedge w_clk);
    check_val("t4_clr_c1", 32'(fifo_clr), 32'd1);
    check_val("t4_rdy_c1", 32'(in_ready), 32'd0);
    @(negedge w_clk);
    check_val("t4_clr_c2", 32'(fifo_clr), 32'd1);
    check_val("t4_done_c2", 32'(clr_done), 32'd0);
    @(negedge w_clk);
    check_val("t4_clr_c3", 32'(fifo_clr), 32'd0);
    check_val("t4_done_c3", 32'(clr_done), 32'd1);
    check_val("t4_rdy_c3", 32'(in_ready), 32'd0);
    check_val("t4_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge w_clk);
    check_val("t4_done_c4", 32'(clr_done), 32'd0);
    check_val("t4_rdy_c4", 32'(in_ready), 32'd1);
    @(posedge w_clk); #1;
    for (int i = 1; i <= 4; i++) send_beat(8'hE0 + 8'(i), 1'b0);
    idle(2);
    check_val("t4_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) check_val("t4_w0", wq[0], 32'hE4E3E2E1);
    check_val("t4_word_cnt2", 32'(word_cnt), 32'd1);
    wq.delete();

    // 5: asynchronous reset with a word pending
    fifo_full = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(8'hF0 + 8'(i), 1'b0);
    fifo_full = 1'b0;
    #1 check_val("t5_wr_before", 32'(fifo_wr), 32'd1);
    #1 w_reset_n = 1'b0;
    #1 check_val("t5_wr_async", 32'(fifo_wr), 32'd0);
    repeat (2) @(posedge w_clk);
    #1 w_reset_n = 1'b1;
    @(negedge w_clk);
    check_val("t5_ready", 32'(in_ready), 32'd1);
    idle(3);
    check_val("t5_no_wr", 32'(wq.size()), 32'd0);
    check_val("t5_word_cnt", 32'(word_cnt), 32'd0);
    wq.delete();
    wc.delete();

    // 6: continuous stream of 64 beats
    t6 = 1'b1;
    for (int i = 0; i < 64; i++) send_beat(8'(i), 1'b0);
    t6 = 1'b0;
    idle(2);
    check_val("t6_stall", 32'(stall), 32'd0);
    check_val("t6_nwr", 32'(wq.size()), 32'd16);
    if (wq.size() == 16) begin
      check_val("t6_w0", wq[0], 32'h03020100);
      check_val("t6_w15", wq[15], 32'h3F3E3D3C);
      check_val("t6_span", 32'(wc[15] - wc[0]), 32'd60);
    end
    check_val("t6_word_cnt", 32'(word_cnt), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
